mips_fetch_unit: RTL
====================

// Module: mips_fetch_unit
// PURPOSE
//  Upstream instruction-fetch stage for MIPSController. Holds the PC, fetches each instruction from
//  instruction memory over a req/ack handshake, and presents opCode/functionCode to the controller.
//  Consumes the controller's PCSrc/PCsignal/jumpSrc to form the next PC on instruction retirement.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset; bits[1:0] must be 0
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  imem_req      out  1   fetch request, held high until imem_ack
//  imem_addr     out  32  word-aligned fetch address (= pc), stable while imem_req=1
//  imem_ack      in   1   instruction-memory ack; imem_rdata valid in same cycle
//  imem_rdata    in   32  fetched instruction word
//  instr         out  32  instruction register (IR)
//  opCode        out  6   IR[31:26], to controller
//  functionCode  out  6   IR[5:0], to controller
//  instr_valid   out  1   high throughout EXEC; controller outputs are meaningful only then
//  pc            out  32  address of the instruction in IR
//  pc_plus4      out  32  pc+4 (jal link value)
//  exec_done     in   1   datapath finished current instruction; retire this cycle
//  PCSrc         in   1   branch taken
//  PCsignal      in   1   jump class (j/jal/jr)
//  jumpSrc       in   1   1 = J-type target, 0 = register target
//  reg_target    in   32  rs register value for jr
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0; after rst_n
//   rises, imem_req asserts on the first clk edge.
//  FSM: FETCH -> EXEC -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, -> EXEC. Ack in first req cycle
//    is accepted (min fetch latency 1 clk). imem_ack outside FETCH is ignored.
//   EXEC: instr_valid=1, imem_req=0. Wait for exec_done (any number of cycles). On exec_done:
//    pc<=next_pc, -> FETCH. instr held unchanged until the next ack.
//  next_pc (priority order):
//   PCsignal&jumpSrc   -> {pc_plus4[31:28], instr[25:0], 2'b00}
//   PCsignal&~jumpSrc  -> {reg_target[31:2], 2'b00} (low bits forced 0)
//   PCSrc              -> pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
//   else               -> pc_plus4
//  PCsignal and PCSrc both high: jump wins. All adds are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
//  Control inputs sampled only in the EXEC cycle with exec_done=1.
//  Reset mid-fetch: imem_req drops asynchronously; any late ack after reset is in FETCH with a new
//   request and is accepted as the RESET_PC instruction (memory must drop stale acks on rst_n).
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs retired_cnt[31:0] (+1 per exec_done in EXEC) and
//   redirect_cnt[31:0] (+1 per retirement whose next_pc != pc_plus4); both reset to 0, wrap at 2^32.
//  Not defined: ports and counters absent; no other behaviour change.
// STRUCTURE
//  Package mips_fetch_pkg: fetch_state_t enum {FETCH, EXEC}; opcode/field-slice constants
//   (OPC_MSB=31, OPC_LSB=26, FUNCT_MSB=5, IMM_W=16, JIDX_W=26).
//  Sub-module mips_next_pc: combinational next-PC mux (pc_plus4, instr, reg_target, PCSrc,
//   PCsignal, jumpSrc -> next_pc); FSM, PC and IR registers stay in mips_fetch_unit.
// TESTING
//  1 Reset, ack 1 clk after req, rdata=32'h2008_0005 (addi), exec_done -> addr 0 then 4; opCode=6'h08.
//  2 pc=32'h40, instr beq imm=16'hFFFF, PCSrc=1 -> next imem_addr=32'h40; PCSrc=0 -> 32'h44.
//  3 pc=32'h1000_0000, j index 26'h10 -> imem_addr=32'h1000_0040; PCSrc=1 also high -> still 0x1000_0040.
//  4 jr (PCsignal=1,jumpSrc=0) reg_target=32'h0000_0123 -> imem_addr=32'h0000_0120.
//  5 ack delayed 5 clks, exec_done delayed 3 clks -> imem_req high 6 clks, addr stable, one retire.
//  6 rst_n low mid-FETCH at pc=32'h80 -> imem_req=0 immediately, restart at RESET_PC; PERF counts 0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch_pkg
// Purpose  : Shared types and instruction field constants for the MIPS
//            instruction-fetch stage (mips_fetch_unit, mips_next_pc).
// Contents : fetch_state_t  - fetch FSM state encoding {FETCH, EXEC}
//            OPC_MSB/OPC_LSB - opcode field position in the instruction word
//            FUNCT_MSB       - top bit of the R-type function field
//            IMM_W           - I-type immediate width
//            JIDX_W          - J-type target index width
// Revision : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int FUNCT_MSB = 5;
    localparam int IMM_W     = 16;
    localparam int JIDX_W    = 26;

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/mips_next_pc.sv
`default_nettype none
// ============================================================================
// Module   : mips_next_pc
// Purpose  : Combinational next-PC selection for the fetch stage.
//            Priority: J-type jump, register jump, taken branch, sequential.
// Ports    : pc_plus4   in  32  address of the instruction after the current one
//            instr      in  32  current instruction register contents
//            reg_target in  32  rs value used by jr
//            PCSrc      in   1  branch taken
//            PCsignal   in   1  jump class (j/jal/jr)
//            jumpSrc    in   1  1 = J-type target, 0 = register target
//            next_pc    out 32  selected next fetch address
// Revision : 1.0 - initial release
// ============================================================================
module mips_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] reg_target,
    input  logic        PCSrc,
    input  logic        PCsignal,
    input  logic        jumpSrc,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] reg_jump_target;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;

    // J-type target stays inside the 256 MB region of the delay-slot address.
    assign jump_target     = {pc_plus4[31:28], instr[JIDX_W-1:0], 2'b00};
    // Register targets are forced word-aligned rather than trapping.
    assign reg_jump_target = {reg_target[31:2], 2'b00};
    assign branch_offset   = {{(32-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
    assign branch_target   = pc_plus4 + branch_offset;

    always_comb begin
        next_pc = pc_plus4;
        if (PCsignal) begin
            next_pc = jumpSrc ? jump_target : reg_jump_target;
        end else if (PCSrc) begin
            next_pc = branch_target;
        end
    end

    // Opcode bits and the low rs bits play no part in target formation.
    logic unused_bits;
    assign unused_bits = ^{instr[31:JIDX_W], reg_target[1:0]};

endmodule : mips_next_pc
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch_unit
// Purpose  : Instruction-fetch stage feeding the MIPS controller. Holds the PC
//            and instruction register, fetches over a req/ack handshake and
//            forms the next PC when the current instruction retires.
// Config   : FETCH_PERF_EN - when defined, adds retired_cnt / redirect_cnt
//            performance counters as output ports.
// Ports    : clk, rst_n (async, active-low)
//            imem_req/imem_addr out, imem_ack/imem_rdata in - fetch handshake
//            instr, opCode, functionCode, instr_valid, pc, pc_plus4 out
//            exec_done, PCSrc, PCsignal, jumpSrc, reg_target in - retirement
//            retired_cnt, redirect_cnt out (FETCH_PERF_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [5:0]  functionCode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        PCSrc,
    input  logic        PCsignal,
    input  logic        jumpSrc,
    input  logic [31:0] reg_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         req_next;
    logic         load_ir;
    logic         retire;
    logic [31:0]  next_pc;

    // ------------------------------------------------------------------
    // FSM state register. imem_req is registered so it stays low during
    // reset and rises on the first clock edge afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            imem_req <= 1'b0;
        end else begin
            state    <= state_next;
            imem_req <= req_next;
        end
    end

    always_comb begin
        state_next = state;
        req_next   = imem_req;
        load_ir    = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                req_next = 1'b1;
                // Only an ack against an outstanding request is accepted.
                if (imem_req && imem_ack) begin
                    load_ir    = 1'b1;
                    req_next   = 1'b0;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                req_next = 1'b0;
                if (exec_done) begin
                    retire     = 1'b1;
                    req_next   = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
                req_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC and instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= 32'h0000_0000;
        end else begin
            if (load_ir) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc <= next_pc;
            end
        end
    end

    assign pc_plus4     = pc + 32'd4;
    assign imem_addr    = pc;
    assign instr_valid  = (state == EXEC);
    assign opCode       = instr[OPC_MSB:OPC_LSB];
    assign functionCode = instr[FUNCT_MSB:0];

    mips_next_pc u_next_pc (
        .pc_plus4   (pc_plus4),
        .instr      (instr),
        .reg_target (reg_target),
        .PCSrc      (PCSrc),
        .PCsignal   (PCsignal),
        .jumpSrc    (jumpSrc),
        .next_pc    (next_pc)
    );

`ifdef FETCH_PERF_EN
    // Redirect means control flow left the sequential path, whatever the
    // reason (a taken branch to pc+4 does not count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt  <= 32'd0;
            redirect_cnt <= 32'd0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 32'd1;
            if (next_pc != pc_plus4) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : mips_fetch_unit
`default_nettype wire
